// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types and constants
//
// hz_state_t : hazard unit FSM states (RUN, MEM_WAIT, TIMEOUT)
// REG_ZERO   : architectural x0, which never creates a data hazard
// NOP_INSTR  : canonical NOP (addi x0, x0, 0) loaded into flushed registers
// WAIT_W     : width of the data-memory wait watchdog counter
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          WAIT_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
//
// clk    : rising-edge clock
// arst_n : asynchronous active-low reset, value -> 0
// inc_en : add one this edge unless already all-ones
// clr    : synchronous clear, wins over inc_en
// value  : current count
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc_en,
    input  logic             clr,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc_en && (value != {WIDTH{1'b1}})) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush controller for the 5-stage pipeline
//
// Inputs : clk, arst_n (async active-low), rs1_IFID/rs2_IFID and their use
//          flags, rd_IDEX, mem_read_IDEX, branch_taken_EX, dmem_busy,
//          stall_clr (clears stall_cycles next edge)
// Outputs: pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze
//          (same-cycle decode), mem_timeout (sticky watchdog flag),
//          stall_cycles (saturating count of cycles with pc_write=0)
module hazard_stall_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_MEM_WAIT = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       rs1_IFID,
    input  logic [4:0]       rs2_IFID,
    input  logic             use_rs1_IFID,
    input  logic             use_rs2_IFID,
    input  logic [4:0]       rd_IDEX,
    input  logic             mem_read_IDEX,
    input  logic             branch_taken_EX,
    input  logic             dmem_busy,
    input  logic             stall_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_MEM_WAIT);

    hz_state_t         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              load_use;
    logic              rs1_hit, rs2_hit;

    // Only a load still in EX can't be forwarded in time; x0 is never written.
    assign rs1_hit  = use_rs1_IFID && (rd_IDEX == rs1_IFID);
    assign rs2_hit  = use_rs2_IFID && (rd_IDEX == rs2_IFID);
    assign load_use = mem_read_IDEX && (rd_IDEX != REG_ZERO) && (rs1_hit || rs2_hit);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Watchdog: wait_cnt counts busy cycles seen in the current burst. The
    // trip check happens before incrementing, so a burst of exactly
    // MAX_MEM_WAIT cycles ends in RUN and the counter never exceeds the limit.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            RUN: begin
                if (dmem_busy) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (!dmem_busy) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt    = TIMEOUT;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            TIMEOUT: begin
                state_nxt = TIMEOUT;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Strict-priority decode: freeze > taken branch > load-use > run.
    // A taken branch wins over load-use because the ID instruction is on the
    // wrong path and is being flushed anyway.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if ((state == TIMEOUT) || dmem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (branch_taken_EX) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // state is a flop, so this is a registered flag that holds until reset.
    assign mem_timeout = (state == TIMEOUT);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc_en (~pc_write),
        .clr    (stall_clr),
        .value  (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

    localparam int MAXW = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [4:0]    rs1_IFID, rs2_IFID, rd_IDEX;
    logic          use_rs1_IFID, use_rs2_IFID, mem_read_IDEX;
    logic          branch_taken_EX, dmem_busy, stall_clr;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble;
    logic          pipe_freeze, mem_timeout;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .MAX_MEM_WAIT (MAXW),
        .CNT_W        (CW)
    ) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .rs1_IFID        (rs1_IFID),
        .rs2_IFID        (rs2_IFID),
        .use_rs1_IFID    (use_rs1_IFID),
        .use_rs2_IFID    (use_rs2_IFID),
        .rd_IDEX         (rd_IDEX),
        .mem_read_IDEX   (mem_read_IDEX),
        .branch_taken_EX (branch_taken_EX),
        .dmem_busy       (dmem_busy),
        .stall_clr       (stall_clr),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_freeze     (pipe_freeze),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles)
    );

    typedef struct packed {
        logic          pcw;
        logic          ifw;
        logic          fl;
        logic          bub;
        logic          frz;
        logic          to;
        logic [CW-1:0] sc;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    // Reference model state: 0=RUN 1=MEM_WAIT 2=TIMEOUT
    int m_state = 0;
    int m_cnt   = 0;
    int m_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic busy, input logic clr);
        exp_t e;
        logic lu;
        @(negedge clk);
        rs1_IFID = r1; rs2_IFID = r2; use_rs1_IFID = u1; use_rs2_IFID = u2;
        rd_IDEX = rd; mem_read_IDEX = mr; branch_taken_EX = br;
        dmem_busy = busy; stall_clr = clr;

        lu = mr && (rd != 5'd0) && ((u1 && rd == r1) || (u2 && rd == r2));
        e = '{pcw: 1'b1, ifw: 1'b1, fl: 1'b0, bub: 1'b0, frz: 1'b0,
              to: (m_state == 2), sc: CW'(m_stall)};
        if (m_state == 2 || busy) begin
            e.frz = 1'b1; e.pcw = 1'b0; e.ifw = 1'b0;
        end else if (br) begin
            e.fl = 1'b1; e.bub = 1'b1;
        end else if (lu) begin
            e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1;
        end
        sb.push_back(e);

        #2;
        e = sb.pop_front();
        chk({phase, ".pc_write"},     32'(pc_write),     32'(e.pcw));
        chk({phase, ".ifid_write"},   32'(ifid_write),   32'(e.ifw));
        chk({phase, ".ifid_flush"},   32'(ifid_flush),   32'(e.fl));
        chk({phase, ".idex_bubble"},  32'(idex_bubble),  32'(e.bub));
        chk({phase, ".pipe_freeze"},  32'(pipe_freeze),  32'(e.frz));
        chk({phase, ".mem_timeout"},  32'(mem_timeout),  32'(e.to));
        chk({phase, ".stall_cycles"}, 32'(stall_cycles), 32'(e.sc));

        // advance model across the coming rising edge
        if (clr) m_stall = 0;
        else if (!e.pcw && m_stall < (1 << CW) - 1) m_stall++;
        case (m_state)
            0: if (busy) begin m_state = 1; m_cnt = 1; end
            1: begin
                if (!busy) begin m_state = 0; m_cnt = 0; end
                else if (m_cnt == MAXW) m_state = 2;
                else m_cnt++;
            end
            default: m_state = 2;
        endcase
    endtask

    task automatic idle();
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset(input logic busy);
        @(negedge clk);
        arst_n = 1'b0;
        rs1_IFID = '0; rs2_IFID = '0; use_rs1_IFID = 0; use_rs2_IFID = 0;
        rd_IDEX = '0; mem_read_IDEX = 0; branch_taken_EX = 0;
        dmem_busy = busy; stall_clr = 0;
        #1;
        chk({phase, ".rst.mem_timeout"},  32'(mem_timeout),  32'd0);
        chk({phase, ".rst.stall_cycles"}, 32'(stall_cycles), 32'd0);
        chk({phase, ".rst.pipe_freeze"},  32'(pipe_freeze),  32'(busy));
        chk({phase, ".rst.pc_write"},     32'(pc_write),     32'(!busy));
        m_state = 0; m_cnt = 0; m_stall = 0;
        @(posedge clk);
        #2;
        dmem_busy = 1'b0;
        arst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        arst_n = 1'b0;
        rs1_IFID = '0; rs2_IFID = '0; use_rs1_IFID = 0; use_rs2_IFID = 0;
        rd_IDEX = '0; mem_read_IDEX = 0; branch_taken_EX = 0;
        dmem_busy = 0; stall_clr = 0;

        phase = "reset";
        pulse_reset(1'b0);
        idle();

        phase = "load_use";
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("load_use.count", 32'(stall_cycles), 32'd1);

        phase = "x0_unused";
        step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        phase = "branch_lu";
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();

        phase = "mem_wait";
        pulse_reset(1'b0);
        for (int i = 0; i < 3; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("mem_wait.count", 32'(stall_cycles), 32'd3);

        phase = "wd_edge";
        for (int i = 0; i < MAXW; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        chk("wd_edge.no_trip", 32'(mem_timeout), 32'd0);

        phase = "wd_trip";
        for (int i = 0; i < MAXW + 1; i++)
            step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        chk("wd_trip.sticky", 32'(mem_timeout), 32'd1);

        phase = "wd_reset";
        pulse_reset(1'b1);
        idle();

        phase = "random";
        for (int i = 0; i < 40; i++)
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 1'($urandom), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));

        phase = "saturate";
        pulse_reset(1'b0);
        for (int i = 0; i < 20; i++)
            step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("saturate.value", 32'(stall_cycles), 32'd15);
        phase = "clear";
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("clear.after_one_stall", 32'(stall_cycles), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Stall/flush controller for the 5-stage pipeline; the counterpart to the forwarding path.
- Handles the hazards forwarding cannot resolve:
  - load-use: a bubble is inserted into ID/EX.
  - taken branch resolved in EX: IF/ID is flushed.
  - multi-cycle data-memory wait: the whole pipeline freezes.
- Also keeps a data-memory wait watchdog and a saturating stall-cycle performance counter.
- Sits beside the ID stage and drives the PC and the pipeline-register enables.

Parameters:
- MAX_MEM_WAIT, 16, consecutive dmem_busy cycles before the watchdog trips (range 1..255).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- rs1_IFID  in  5  source register 1 of the instruction in ID.
- rs2_IFID  in  5  source register 2 of the instruction in ID.
- use_rs1_IFID  in  1  the ID instruction reads rs1.
- use_rs2_IFID  in  1  the ID instruction reads rs2.
- rd_IDEX  in  5  destination register of the instruction in EX.
- mem_read_IDEX  in  1  the EX instruction is a load.
- branch_taken_EX  in  1  a branch or jump in EX is taken.
- dmem_busy  in  1  data memory is not ready this cycle.
- stall_clr  in  1  synchronous clear of stall_cycles.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  load a NOP (control bits zero) into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mem_timeout  out  1  sticky watchdog error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- Combinational detection terms:
  - load_use = mem_read_IDEX & (rd_IDEX!=0) & ((use_rs1_IFID & rd_IDEX==rs1_IFID) | (use_rs2_IFID & rd_IDEX==rs2_IFID)).
  - Register x0 never triggers a hazard.
- FSM states (registered): RUN, MEM_WAIT, TIMEOUT.
- FSM transitions:
  - RUN->MEM_WAIT when dmem_busy=1; wait_cnt is loaded with 1.
  - MEM_WAIT stays while dmem_busy=1 and wait_cnt increments.
  - MEM_WAIT->TIMEOUT when dmem_busy=1 and wait_cnt==MAX_MEM_WAIT.
  - MEM_WAIT->RUN when dmem_busy=0; wait_cnt is cleared.
  - TIMEOUT is terminal until reset.
- Output decode (Mealy, same-cycle response, strict priority):
  1. Freeze, when state==TIMEOUT or dmem_busy=1: pipe_freeze=1, pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
  2. Branch, when branch_taken_EX=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. The branch overrides a simultaneous load_use, because the ID instruction is wrong-path.
  3. Load-use, when load_use=1: pc_write=0, ifid_write=0, idex_bubble=1. This gives exactly one bubble, since the next cycle ID/EX holds the NOP and load_use clears.
  4. Otherwise: pc_write=1, ifid_write=1, all other outputs 0.
- mem_timeout is registered and equals 1 exactly while state==TIMEOUT.
- stall_cycles:
  - Registered; increments by 1 on each cycle with pc_write=0.
  - Saturates at all-ones.
  - stall_clr has priority over increment and takes effect next edge.
- Reset values (arst_n=0, applied immediately):
  - State RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
  - Combinational outputs follow the rules above in state RUN, so pc_write=1 and ifid_write=1 with idle inputs.
- Reset mid-MEM_WAIT or in TIMEOUT: returns to RUN with wait_cnt=0. pipe_freeze still follows dmem_busy combinationally.
- Watchdog arithmetic:
  - wait_cnt is 8 bits and never wraps.
  - A busy burst of exactly MAX_MEM_WAIT cycles followed by ready does not trip; MAX_MEM_WAIT+1 busy cycles does.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum hz_state_t {RUN, MEM_WAIT, TIMEOUT}.
  - constant REG_ZERO = 5'd0.
  - NOP encoding constant, shared with the pipeline registers.
- One sub-module, sat_counter (parameter WIDTH; ports: increment enable, synchronous clear, value), used for stall_cycles.

Test Plan:
- Load-use: lw x5 in EX (mem_read_IDEX=1, rd_IDEX=5), ID reads rs1=5 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1, stall_cycles 0->1. Next cycle, with mem_read_IDEX=0, normal flow.
- x0 and unused source: rd_IDEX=0 with rs1=0, then rd_IDEX=7 with rs2=7 and use_rs2_IFID=0 -> no stall; pc_write=1 both cycles.
- Branch plus load-use in the same cycle: branch_taken_EX=1 with load_use=1 -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall count.
- Memory wait: dmem_busy=1 for 3 cycles, branch_taken_EX=1 throughout -> pipe_freeze=1 and pc_write=0 for 3 cycles, then flush on the first ready cycle; stall_cycles=3.
- Watchdog with MAX_MEM_WAIT=4:
  - 4 busy cycles -> no timeout.
  - 5 busy cycles -> mem_timeout=1, pipeline stays frozen after dmem_busy drops.
  - arst_n pulse -> RUN, mem_timeout=0, stall_cycles=0.
- Saturation and clear with CNT_W=4: 20 load-use stalls -> stall_cycles=15; then stall_clr=1 -> 0 on the next edge, even while a stall is active.
